bus_arbiter: RTL

Parametrised, registered datapath bus for the CPU. It replaces a flat combinational enable-mux with two selection mechanisms. Round-robin arbitration serves NSRC requesters, and each grant is bounded by a hold limit. A direct-drive force path keeps the existing per-register `out` enable style and takes priority over arbitration. The bus value is registered and keeps its last value when idle, so no latch is inferred.

---
 rtl/bus_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/bus_arbiter.sv
// Registered CPU datapath bus: a direct-drive force path with priority over
// round-robin arbitration, where each grant is bounded by a hold limit
// while other sources are waiting.
module bus_arbiter #(
  parameter int WIDTH    = 32,
  parameter int NSRC     = 20,
  parameter int MAX_HOLD = 4,
  parameter int SW       = $clog2(NSRC)
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic [NSRC-1:0]       req,
  input  logic [NSRC-1:0]       force_en,
  input  logic [NSRC*WIDTH-1:0] data_in,
  output logic [NSRC-1:0]       gnt,
  output logic [WIDTH-1:0]      bus_out,
  output logic                  bus_valid,
  output logic [SW-1:0]         bus_src,
  output logic                  multi_err
);

  // The hold counter must be able to hold the value MAX_HOLD itself.
  localparam int HW = $clog2(MAX_HOLD + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t              state, state_next;
  logic [SW-1:0]       owner, owner_next;
  logic [SW-1:0]       ptr, ptr_next;
  logic [HW-1:0]       hold_cnt, hold_next;
  logic [NSRC-1:0]     gnt_next;
  logic [WIDTH-1:0]    bus_next;
  logic                valid_next;
  logic [SW-1:0]       src_next;
  logic                merr_next;

  logic [WIDTH-1:0]    src_data [NSRC];
  logic [SW-1:0]       force_sel;
  logic                force_multi;
  logic [NSRC-1:0]     owner_mask;
  logic                others;
  logic                keep;
  logic [NSRC-1:0]     cand;
  logic [SW-1:0]       start;
  logic                pick_hit;
  logic [SW-1:0]       pick_idx;
  logic                load;
  logic [SW-1:0]       load_idx;

  // Index successor with wrap at NSRC-1 (NSRC need not be a power of two).
  function automatic logic [SW-1:0] next_idx(input logic [SW-1:0] x);
    return (x == SW'(NSRC - 1)) ? '0 : x + SW'(1);
  endfunction

  // Unpack the flat source vector into one word per source.
  for (genvar gi = 0; gi < NSRC; gi++) begin : g_unpack
    assign src_data[gi] = data_in[gi*WIDTH +: WIDTH];
  end

  assign owner_mask  = NSRC'(1) << owner;
  assign others      = |(req & ~owner_mask);
  assign force_multi = |(force_en & (force_en - NSRC'(1)));
  assign keep        = (state == GRANT) && req[owner] &&
                       ((hold_cnt < HW'(MAX_HOLD)) || !others);

  // Highest set force_en bit wins, so the last enable in index order drives.
  always_comb begin
    force_sel = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (force_en[i]) force_sel = SW'(i);
    end
  end

  // Round-robin search: from ptr when idle, from owner+1 (owner masked) on release.
  always_comb begin
    cand     = (state == GRANT) ? (req & ~owner_mask) : req;
    start    = (state == GRANT) ? next_idx(owner) : ptr;
    pick_hit = 1'b0;
    pick_idx = '0;
    for (int k = 0; k < NSRC; k++) begin
      int idx;
      idx = int'(start) + k;
      if (idx >= NSRC) idx = idx - NSRC;
      if (!pick_hit && cand[idx]) begin
        pick_hit = 1'b1;
        pick_idx = SW'(idx);
      end
    end
  end

  // Next-state and output decision: force, keep, hand over, or go idle.
  always_comb begin
    state_next = state;
    owner_next = owner;
    ptr_next   = ptr;
    hold_next  = hold_cnt;
    gnt_next   = gnt;
    bus_next   = bus_out;
    valid_next = 1'b0;
    src_next   = bus_src;
    merr_next  = 1'b0;
    load       = 1'b0;
    load_idx   = owner;

    if (|force_en) begin
      load       = 1'b1;
      load_idx   = force_sel;
      gnt_next   = '0;
      merr_next  = force_multi;
      state_next = IDLE;
      hold_next  = '0;
    end else if (keep) begin
      load      = 1'b1;
      load_idx  = owner;
      gnt_next  = owner_mask;
      hold_next = (hold_cnt == HW'(MAX_HOLD)) ? hold_cnt : hold_cnt + HW'(1);
    end else if (pick_hit) begin
      load       = 1'b1;
      load_idx   = pick_idx;
      state_next = GRANT;
      owner_next = pick_idx;
      gnt_next   = NSRC'(1) << pick_idx;
      hold_next  = HW'(1);
      ptr_next   = next_idx(pick_idx);
    end else begin
      state_next = IDLE;
      gnt_next   = '0;
    end

    if (load) begin
      bus_next   = src_data[load_idx];
      src_next   = load_idx;
      valid_next = 1'b1;
    end
  end

  // State and registered outputs; clear drops ownership without a clock edge.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state     <= IDLE;
      owner     <= '0;
      ptr       <= '0;
      hold_cnt  <= '0;
      gnt       <= '0;
      bus_out   <= '0;
      bus_valid <= 1'b0;
      bus_src   <= '0;
      multi_err <= 1'b0;
    end else begin
      state     <= state_next;
      owner     <= owner_next;
      ptr       <= ptr_next;
      hold_cnt  <= hold_next;
      gnt       <= gnt_next;
      bus_out   <= bus_next;
      bus_valid <= valid_next;
      bus_src   <= src_next;
      multi_err <= merr_next;
    end
  end

endmodule
